// File: rtl/reminder_pkg.sv
// Shared types and constants for the reminder alert block: FSM state encoding
// and the BCD ceiling for the missed-alert counter.
package reminder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ALERT  = 2'd1,
        ST_SNOOZE = 2'd2,
        ST_ACKED  = 2'd3
    } alert_state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

    // Single-digit BCD increment that sticks at 9 instead of wrapping.
    function automatic logic [3:0] bcd_sat_inc(input logic [3:0] v);
        return (v >= BCD_MAX) ? BCD_MAX : v + 4'd1;
    endfunction

endpackage

// File: rtl/debouncer.sv
// Pushbutton conditioning: 2-flop synchronizer, stable-level debouncer and a
// one-cycle pulse on each rising edge of the accepted level.
module debouncer #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise_pulse
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic          sync1;
    logic          sync2;
    logic          level_q;
    logic          level_d1;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            level_q  <= 1'b0;
            level_d1 <= 1'b0;
            cnt      <= '0;
        end else begin
            sync1    <= din;
            sync2    <= sync1;
            level_d1 <= level_q;
            // Any cycle where the input agrees with the accepted level restarts the run.
            if (sync2 == level_q) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                level_q <= sync2;
                cnt     <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign rise_pulse = level_q & ~level_d1;

endmodule

// File: rtl/reminder_alert.sv
// Drink-reminder alert controller: flashes led/buzzer on a reminder, counts
// unacknowledged alerts in BCD, snoozes and re-alerts until acknowledged.
module reminder_alert
    import reminder_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int ALERT_TICKS     = 10,
    parameter int SNOOZE_TICKS    = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       remind,
    input  logic       ack_btn,
    input  logic       clear_missed,
    output logic       buzzer,
    output logic       led,
    output logic [3:0] missed_count,
    output logic [1:0] alert_state
);

    localparam int TICK_MAX = (ALERT_TICKS > SNOOZE_TICKS) ? ALERT_TICKS : SNOOZE_TICKS;
    localparam int TW       = $clog2(TICK_MAX + 1);

    alert_state_t  state_q, state_d;
    logic [TW-1:0] tick_q, tick_d;
    logic          led_q, led_d;
    logic          buzz_q, buzz_d;
    logic [3:0]    miss_q, miss_d;
    logic          miss_inc;
    logic          remind_q;
    logic          remind_rise;
    logic          ack_pulse;

    debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ack_debounce (
        .clk       (clk),
        .reset     (reset),
        .din       (ack_btn),
        .rise_pulse(ack_pulse)
    );

    assign remind_rise = remind & ~remind_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            tick_q   <= '0;
            led_q    <= 1'b0;
            buzz_q   <= 1'b0;
            miss_q   <= 4'd0;
            remind_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            tick_q   <= tick_d;
            led_q    <= led_d;
            buzz_q   <= buzz_d;
            miss_q   <= miss_d;
            remind_q <= remind;
        end
    end

    always_comb begin
        state_d  = state_q;
        tick_d   = tick_q;
        led_d    = led_q;
        miss_inc = 1'b0;
        case (state_q)
            ST_IDLE: begin
                led_d = 1'b0;
                if (remind_rise) begin
                    state_d = ST_ALERT;
                    tick_d  = '0;
                    led_d   = 1'b1;
                end
            end
            ST_ALERT: begin
                // Acknowledge beats a dropped reminder, which beats the timeout.
                if (ack_pulse) begin
                    state_d = ST_ACKED;
                    tick_d  = '0;
                    led_d   = 1'b1;
                end else if (!remind) begin
                    state_d = ST_IDLE;
                    tick_d  = '0;
                    led_d   = 1'b0;
                end else if (tick) begin
                    if (tick_q == TW'(ALERT_TICKS - 1)) begin
                        state_d  = ST_SNOOZE;
                        tick_d   = '0;
                        led_d    = 1'b0;
                        miss_inc = 1'b1;
                    end else begin
                        tick_d = tick_q + 1'b1;
                        led_d  = ~led_q;
                    end
                end
            end
            ST_SNOOZE: begin
                led_d = 1'b0;
                if (ack_pulse) begin
                    state_d = ST_ACKED;
                    tick_d  = '0;
                    led_d   = 1'b1;
                end else if (!remind) begin
                    state_d = ST_IDLE;
                    tick_d  = '0;
                end else if (tick) begin
                    if (tick_q == TW'(SNOOZE_TICKS - 1)) begin
                        state_d = ST_ALERT;
                        tick_d  = '0;
                        led_d   = 1'b1;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            ST_ACKED: begin
                led_d = 1'b1;
                if (!remind) begin
                    state_d = ST_IDLE;
                    tick_d  = '0;
                    led_d   = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                tick_d  = '0;
                led_d   = 1'b0;
            end
        endcase

        buzz_d = (state_d == ST_ALERT) ? led_d : 1'b0;

        if (clear_missed) begin
            miss_d = 4'd0;
        end else if (miss_inc) begin
            miss_d = bcd_sat_inc(miss_q);
        end else begin
            miss_d = miss_q;
        end
    end

    assign buzzer       = buzz_q;
    assign led          = led_q;
    assign missed_count = miss_q;
    assign alert_state  = state_q;

endmodule

// File: tb/tb_reminder_alert.sv
// Bench for reminder_alert: directed scenarios plus a randomized stretch, all
// checked every cycle against a tick-counting reference model.
module tb_reminder_alert;

    localparam int DB = 4;
    localparam int AT = 10;
    localparam int ST = 5;

    localparam int M_IDLE   = 0;
    localparam int M_ALERT  = 1;
    localparam int M_SNOOZE = 2;
    localparam int M_ACKED  = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick;
    logic       remind;
    logic       ack_btn;
    logic       clear_missed;
    logic       buzzer;
    logic       led;
    logic [3:0] missed_count;
    logic [1:0] alert_state;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: mode, ticks seen in the current mode, total misses since clear.
    int m_mode;
    int m_ticks;
    int m_misses;
    bit m_prev_r;
    bit m_lvl;
    bit m_pend;
    bit m_hist[DB+2];

    always #5 clk = ~clk;

    reminder_alert #(
        .DEBOUNCE_CYCLES(DB),
        .ALERT_TICKS    (AT),
        .SNOOZE_TICKS   (ST)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .tick        (tick),
        .remind      (remind),
        .ack_btn     (ack_btn),
        .clear_missed(clear_missed),
        .buzzer      (buzzer),
        .led         (led),
        .missed_count(missed_count),
        .alert_state (alert_state)
    );

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode   = M_IDLE;
        m_ticks  = 0;
        m_misses = 0;
        m_prev_r = 1'b0;
        m_lvl    = 1'b0;
        m_pend   = 1'b0;
        foreach (m_hist[i]) m_hist[i] = 1'b0;
    endtask

    task automatic enter(input int mode);
        m_mode  = mode;
        m_ticks = 0;
    endtask

    task automatic model_step();
        bit ack_ev;
        bit miss;
        bit all_diff;
        bit r;
        r      = remind;
        ack_ev = m_pend;
        for (int i = DB + 1; i > 0; i--) m_hist[i] = m_hist[i-1];
        m_hist[0] = ack_btn;
        // Button accepted once the last DB synchronized samples all disagree with it.
        all_diff = 1'b1;
        for (int i = 2; i < DB + 2; i++) if (m_hist[i] == m_lvl) all_diff = 1'b0;
        m_pend = 1'b0;
        if (all_diff) begin
            m_lvl  = !m_lvl;
            m_pend = m_lvl;
        end
        miss = 1'b0;
        case (m_mode)
            M_IDLE: if (r && !m_prev_r) enter(M_ALERT);
            M_ALERT: begin
                if (ack_ev) enter(M_ACKED);
                else if (!r) enter(M_IDLE);
                else if (tick) begin
                    m_ticks++;
                    if (m_ticks == AT) begin
                        enter(M_SNOOZE);
                        miss = 1'b1;
                    end
                end
            end
            M_SNOOZE: begin
                if (ack_ev) enter(M_ACKED);
                else if (!r) enter(M_IDLE);
                else if (tick) begin
                    m_ticks++;
                    if (m_ticks == ST) enter(M_ALERT);
                end
            end
            default: if (!r) enter(M_IDLE);
        endcase
        if (clear_missed) m_misses = 0;
        else if (miss) m_misses++;
        m_prev_r = r;
    endtask

    task automatic check_all();
        bit exp_led;
        exp_led = (m_mode == M_ALERT) ? (m_ticks % 2 == 0) : (m_mode == M_ACKED);
        check("state", alert_state, 4'(m_mode));
        check("led", led, 4'(exp_led));
        check("buzzer", buzzer, 4'((m_mode == M_ALERT) && exp_led));
        check("missed", missed_count, 4'((m_misses > 9) ? 9 : m_misses));
    endtask

    task automatic cycle(input bit t, input bit r, input bit a, input bit c);
        tick         = t;
        remind       = r;
        ack_btn      = a;
        clear_missed = c;
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    initial begin
        bit rr;
        bit aa;
        reset        = 1'b0;
        tick         = 1'b0;
        remind       = 1'b0;
        ack_btn      = 1'b0;
        clear_missed = 1'b0;
        model_reset();
        #3;
        check_all();
        #9 reset = 1'b1;

        // Unacknowledged alert times out, snoozes, then re-alerts.
        cycle(0, 1, 0, 0);
        check("miss_enter", alert_state, 4'd1);
        repeat (AT) begin
            cycle(1, 1, 0, 0);
            cycle(0, 1, 0, 0);
        end
        check("miss_snooze", alert_state, 4'd2);
        check("miss_count", missed_count, 4'd1);
        repeat (ST) cycle(1, 1, 0, 0);
        check("re_alert", alert_state, 4'd1);

        // Held button acknowledges on the 7th edge; dropping remind returns to idle.
        for (int i = 0; i < 6; i++) cycle(0, 1, 1, 0);
        check("ack_not_yet", alert_state, 4'd1);
        cycle(0, 1, 0, 0);
        check("ack_state", alert_state, 4'd3);
        check("ack_buzzer", buzzer, 4'd0);
        check("ack_led", led, 4'd1);
        cycle(0, 0, 0, 0);
        check("ack_idle", alert_state, 4'd0);
        repeat (8) cycle(0, 0, 0, 0);

        // Bouncing button never qualifies.
        cycle(0, 1, 0, 0);
        for (int i = 0; i < 20; i++) cycle(0, 1, 1'((i / 2) % 2), 0);
        check("bounce_alert", alert_state, 4'd1);
        cycle(0, 0, 0, 0);
        repeat (8) cycle(0, 0, 0, 0);

        // Ack pulse lands on the same edge as the timeout tick.
        cycle(0, 1, 0, 0);
        repeat (AT - 1) cycle(1, 1, 0, 0);
        repeat (6) cycle(0, 1, 1, 0);
        cycle(1, 1, 1, 0);
        check("collide_state", alert_state, 4'd3);
        check("collide_missed", missed_count, 4'd1);
        cycle(0, 0, 0, 0);
        repeat (8) cycle(0, 0, 0, 0);

        // Saturation at 9, then clear wins over a simultaneous miss.
        cycle(0, 0, 0, 1);
        check("clear", missed_count, 4'd0);
        cycle(0, 1, 0, 0);
        repeat (11) begin
            repeat (AT) cycle(1, 1, 0, 0);
            repeat (ST) cycle(1, 1, 0, 0);
        end
        check("saturate", missed_count, 4'd9);
        repeat (AT - 1) cycle(1, 1, 0, 0);
        cycle(1, 1, 0, 1);
        check("clear_wins", missed_count, 4'd0);
        check("clear_snooze", alert_state, 4'd2);

        // Randomized traffic.
        rr = 1'b1;
        aa = 1'b0;
        repeat (400) begin
            if ($urandom_range(0, 39) == 0) rr = !rr;
            if ($urandom_range(0, 7) == 0) aa = !aa;
            cycle(1'($urandom_range(0, 2) == 0), rr, aa, 1'($urandom_range(0, 99) == 0));
        end

        // Asynchronous reset mid-alert, released with remind already high.
        repeat (10) cycle(0, 0, 0, 0);
        cycle(0, 1, 0, 0);
        check("pre_reset_alert", alert_state, 4'd1);
        check("pre_reset_buzzer", buzzer, 4'd1);
        #2 reset = 1'b0;
        #1;
        check("rst_buzzer", buzzer, 4'd0);
        check("rst_led", led, 4'd0);
        check("rst_state", alert_state, 4'd0);
        model_reset();
        #1 reset = 1'b1;
        cycle(0, 1, 0, 0);
        check("post_reset_alert", alert_state, 4'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
